// File: rtl/max_select_reg.sv
// Registered signed two-input maximum selector.
// This is the compare primitive for the max-pooling datapath.
// It captures max(i1, i2) on each enabled edge, records the winner,
// and flags that a result is held. On a tie, i1 wins.
module max_select_reg #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i1,
  input  logic [WIDTH-1:0] i2,
  input  logic             en,
  output logic [WIDTH-1:0] value,
  output logic             sel,
  output logic             valid
);

  logic [WIDTH:0] diff;
  logic           i1_ge;

  // Sign-extend both operands by one bit before subtracting.
  // The WIDTH+1-bit difference then cannot overflow, and its MSB is
  // the true sign of (i1 - i2), even for the most-negative/most-positive extremes.
  always_comb begin
    diff  = {i1[WIDTH-1], i1} - {i2[WIDTH-1], i2};
    i1_ge = ~diff[WIDTH];
  end

  // Capture the winner on enabled edges; hold otherwise; clear asynchronously on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= '0;
      sel   <= 1'b0;
      valid <= 1'b0;
    end else if (en) begin
      value <= i1_ge ? i1 : i2;
      sel   <= ~i1_ge;
      valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_max_select_reg.sv
// Directed bench for max_select_reg.
// It covers the 32-bit instance and an 8-bit instance, which share clock, reset and enable.
module tb_max_select_reg;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en  = 1'b0;
  logic [31:0] i1  = '0;
  logic [31:0] i2  = '0;
  logic [31:0] value;
  logic        sel;
  logic        valid;

  logic [7:0]  a8 = '0;
  logic [7:0]  b8 = '0;
  logic [7:0]  value8;
  logic        sel8;
  logic        valid8;

  int ntests = 0;
  int nfail  = 0;

  always #5 clk = ~clk;

  max_select_reg #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .i1(i1), .i2(i2), .en(en),
    .value(value), .sel(sel), .valid(valid)
  );

  max_select_reg #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .i1(a8), .i2(b8), .en(en),
    .value(value8), .sel(sel8), .valid(valid8)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntests++;
    assert (obs === exp)
    else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk3(input string tag, input logic [31:0] v, input logic s, input logic vl);
    chk({tag, ".value"}, {32'h0, value}, {32'h0, v});
    chk({tag, ".sel"},   {63'h0, sel},   {63'h0, s});
    chk({tag, ".valid"}, {63'h0, valid}, {63'h0, vl});
  endtask

  // drive on the falling edge, then sample just after the next rising edge
  task automatic step(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    i1 = a;
    i2 = b;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // 1. reset, asserted asynchronously before any clock edge
    #1 rst = 1'b1;
    #1;
    chk3("reset_async", 32'h0, 1'b0, 1'b0);
    en = 1'b1;
    i1 = 32'hFFFF_FFFF;
    i2 = 32'hFFFF_FFFE;
    @(posedge clk); #1;
    chk3("reset_held_over_edge", 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk3("first_capture_m1_vs_m2", 32'hFFFF_FFFF, 1'b0, 1'b1);

    // 2. operand sequence
    step(32'd20, 32'hFFFF_FFFE);
    chk3("seq_i1_20", 32'd20, 1'b0, 1'b1);
    step(32'd20, 32'd10);
    chk3("seq_i2_10", 32'd20, 1'b0, 1'b1);
    step(32'd20, 32'd35);
    chk3("seq_i2_35", 32'd35, 1'b1, 1'b1);
    step(32'd5, 32'd35);
    chk3("seq_i1_5", 32'd35, 1'b1, 1'b1);
    step(32'hFFFF_FFFD, 32'd35);
    chk3("seq_i1_m3", 32'd35, 1'b1, 1'b1);
    step(32'd0, 32'd35);
    chk3("seq_i1_0", 32'd35, 1'b1, 1'b1);

    // 3. enable hold
    @(negedge clk);
    en = 1'b0;
    i1 = 32'd100;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk3("hold_en0", 32'd35, 1'b1, 1'b1);
    end
    @(negedge clk);
    en = 1'b1;
    @(posedge clk); #1;
    chk3("resume_en1", 32'd100, 1'b0, 1'b1);

    // inputs changed between edges must not reach the outputs early
    @(negedge clk);
    i1 = 32'd1;
    i2 = 32'd50;
    #2;
    chk3("no_comb_path", 32'd100, 1'b0, 1'b1);
    @(posedge clk); #1;
    chk3("after_edge_50", 32'd50, 1'b1, 1'b1);

    // 4. tie, signed cases and extremes
    step(32'd7, 32'd7);
    chk3("tie_7", 32'd7, 1'b0, 1'b1);
    step(32'd0, 32'hFFFF_FFFD);
    chk3("zero_vs_m3", 32'd0, 1'b0, 1'b1);
    step(32'h8000_0000, 32'h7FFF_FFFF);
    chk3("minneg_vs_maxpos", 32'h7FFF_FFFF, 1'b1, 1'b1);
    step(32'h7FFF_FFFF, 32'h8000_0000);
    chk3("maxpos_vs_minneg", 32'h7FFF_FFFF, 1'b0, 1'b1);
    step(32'h8000_0000, 32'h8000_0000);
    chk3("minneg_tie", 32'h8000_0000, 1'b0, 1'b1);
    step(32'hFFFF_FFFE, 32'hFFFF_FFFF);
    chk3("m2_vs_m1", 32'hFFFF_FFFF, 1'b1, 1'b1);

    // 5. async reset in the middle of operation
    step(32'd35, 32'd3);
    chk3("pre_reset_35", 32'd35, 1'b0, 1'b1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk3("mid_reset_async", 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    en = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    chk3("released_en0_no_valid", 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    en = 1'b1;
    i1 = 32'd12;
    i2 = 32'd40;
    @(posedge clk); #1;
    chk3("post_reset_capture", 32'd40, 1'b1, 1'b1);

    // 6. WIDTH=8 instance
    @(negedge clk);
    a8 = 8'h80;
    b8 = 8'h01;
    @(posedge clk); #1;
    chk("w8_m128_vs_1.value", {56'h0, value8}, {56'h0, 8'h01});
    chk("w8_m128_vs_1.sel",   {63'h0, sel8},   64'd1);
    chk("w8_m128_vs_1.valid", {63'h0, valid8}, 64'd1);
    @(negedge clk);
    a8 = 8'h7F;
    b8 = 8'h80;
    @(posedge clk); #1;
    chk("w8_127_vs_m128.value", {56'h0, value8}, {56'h0, 8'h7F});
    chk("w8_127_vs_m128.sel",   {63'h0, sel8},   64'd0);
    @(negedge clk);
    a8 = 8'hFE;
    b8 = 8'hFF;
    @(posedge clk); #1;
    chk("w8_m2_vs_m1.value", {56'h0, value8}, {56'h0, 8'hFF});
    chk("w8_m2_vs_m1.sel",   {63'h0, sel8},   64'd1);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/max_select_reg.md
Name: max_select_reg

Overview:
- Registered, signed two-input maximum selector; the compare primitive for the CNN max-pooling datapath.
- On each enabled rising clock edge it captures the larger of two WIDTH-bit two's-complement operands.
- It also reports which operand won and a result-valid flag.
- Single clock domain; one-cycle latency; output held while disabled.

Parameters:
- WIDTH, 32, operand and result width in bits (two's-complement signed); legal range 2..64.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- i1  input  WIDTH  operand A, signed.
- i2  input  WIDTH  operand B, signed.
- en  input  1  capture enable, sampled on rising clk.
- value  output  WIDTH  registered max(i1, i2), signed.
- sel  output  1  registered winner index: 0 = i1, 1 = i2.
- valid  output  1  high once value holds a computed result.

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Reset:
  - rst high immediately forces value = 0, sel = 0, valid = 0, independent of clk.
  - Outputs stay there while rst is high.
  - First capture is the first rising clk with rst low and en high.
- Compare is signed two's-complement: 32'hFFFFFFFF (-1) > 32'hFFFFFFFE (-2); 0 > -3; 35 > 20.
- Rising clk, rst low, en high:
  - value <= (i1 >= i2) ? i1 : i2.
  - sel <= (i1 >= i2) ? 0 : 1.
  - valid <= 1.
- Tie (i1 == i2): select i1, sel = 0.
- Rising clk, en low: value, sel and valid hold their previous state. Valid does not drop once set; it clears only on reset.
- Latency:
  - Exactly one clock from operand sampling to value update.
  - Input changes between edges do not affect outputs until the next enabled edge.
  - No combinational path from inputs to outputs.
- Extremes must compare correctly with no overflow:
  - max(most-negative, most-positive) = most-positive.
  - max(most-negative, most-negative) = most-negative, sel = 0.
- Reset asserted mid-stream clears outputs at once. Deassertion resumes capture at the next enabled edge.
- No internal state beyond the three output registers.
- Internally, implement the compare as a subtract with sign/overflow correction, or as a signed comparator; both are acceptable.

Test Plan:
1. Reset, then release: rst pulsed high -> value=0, sel=0, valid=0 asynchronously. With en=1, i1=-1, i2=-2, the first edge gives value=32'hFFFFFFFF (-1), sel=0, valid=1.
2. Operand sequence with en=1 and clk period 10:
   - i1=20 (t=12) -> value=20 (0x14), sel=0.
   - i2=10 (t=28) -> 20.
   - i2=35 (t=50) -> 35 (0x23), sel=1.
   - i1=5 (t=79) -> 35.
   - i1=-3 (t=117) -> 35.
   - i1=0 (t=169) -> 35.
   - Each update appears at the first rising edge after the change.
3. Enable hold: value=35; set en=0, i1=100 -> value stays 35 over 5 edges. Set en=1 -> value=100, sel=0 at the next edge.
4. Tie and extremes:
   - i1=i2=7 -> value=7, sel=0.
   - i1=32'h80000000, i2=32'h7FFFFFFF -> value=32'h7FFFFFFF, sel=1.
5. Async reset mid-operation: value=35, valid=1; assert rst between edges -> outputs 0 immediately, without a clock. Release with en=1 -> next edge captures the current max.
6. Parameter sweep: WIDTH=8, i1=8'h80 (-128), i2=8'h01 -> value=8'h01, sel=1.
